// File: rtl/pb_debounce_events_pkg.sv
// Shared types and 50 MHz defaults for the push-button debounce block.
package pb_debounce_events_pkg;

  // Per-channel debounce FSM encoding.
  typedef enum logic [1:0] {
    ST_UP     = 2'd0,
    ST_CNT_DN = 2'd1,
    ST_DN     = 2'd2,
    ST_CNT_UP = 2'd3
  } pb_state_e;

  // 10 ms qualification window at 50 MHz.
  localparam int unsigned PB_DEBOUNCE_CYCLES_50M = 500000;
  localparam int unsigned PB_CNT_W_50M           = 19;
  localparam int unsigned PB_NUM_DEFAULT         = 4;

  // Terminal count: the counter starts at 1 on entry to a CNT_* state,
  // so the window closes when it reaches cycles-1.
  function automatic int unsigned debounce_tc(input int unsigned cycles);
    return cycles - 1;
  endfunction

endpackage

// File: rtl/pb_debounce_events_if.sv
// Button-side bundle: raw pins and flag clears in, conditioned level,
// event pulses and sticky flags out.
interface pb_debounce_events_if #(
  parameter int unsigned NUM_PB = 4
);
  logic [NUM_PB-1:0] pb_n;
  logic [NUM_PB-1:0] flag_clr;
  logic [NUM_PB-1:0] pb_n_db;
  logic [NUM_PB-1:0] press_pulse;
  logic [NUM_PB-1:0] release_pulse;
  logic [NUM_PB-1:0] press_flag;

  // Board/software side: drives pins and clears, observes results.
  modport master (
    output pb_n,
    output flag_clr,
    input  pb_n_db,
    input  press_pulse,
    input  release_pulse,
    input  press_flag
  );

  // Debounce block side.
  modport slave (
    input  pb_n,
    input  flag_clr,
    output pb_n_db,
    output press_pulse,
    output release_pulse,
    output press_flag
  );
endinterface

// File: rtl/pb_debounce_chan.sv
// Single-button conditioner: 2-FF synchroniser, count-based debounce FSM,
// registered press/release pulses and a sticky, software-cleared press flag.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   ST_UP     | button released, pb_n_db=1, counter idle at 0
//   ST_CNT_DN | pin seen low, counting stable-low cycles
//   ST_DN     | button pressed, pb_n_db=0, counter idle at 0
//   ST_CNT_UP | pin seen high, counting stable-high cycles
module pb_debounce_chan
  import pb_debounce_events_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES_50M,
  parameter int unsigned CNT_W           = PB_CNT_W_50M
) (
  input  logic clkin_50,
  input  logic rst_n,
  input  logic pb_n_raw,
  input  logic flag_clr,
  output logic pb_n_db,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_flag
);

  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(debounce_tc(DEBOUNCE_CYCLES));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             pin_s;
  pb_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_done;

  assign pin_s = sync_q[1];

  // Completion of a press qualification; also drives the flag set so that
  // a set always beats a coincident clear.
  assign press_done = (state_q == ST_CNT_DN) && !pin_s && (cnt_q == CNT_TC);

  // Two-stage synchroniser for the asynchronous pin, idle level high.
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], pb_n_raw};
    end
  end

  // Debounce FSM with registered level, pulses and sticky press flag.
  always_ff @(posedge clkin_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_UP;
      cnt_q         <= '0;
      pb_n_db       <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_flag    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state_q)
        ST_UP: begin
          if (!pin_s) begin
            state_q <= ST_CNT_DN;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_CNT_DN: begin
          if (pin_s) begin
            state_q <= ST_UP;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_TC) begin
            state_q     <= ST_DN;
            cnt_q       <= '0;
            pb_n_db     <= 1'b0;
            press_pulse <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_DN: begin
          if (pin_s) begin
            state_q <= ST_CNT_UP;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_CNT_UP: begin
          if (!pin_s) begin
            state_q <= ST_DN;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_TC) begin
            state_q       <= ST_UP;
            cnt_q         <= '0;
            pb_n_db       <= 1'b1;
            release_pulse <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_UP;
          cnt_q   <= '0;
          pb_n_db <= 1'b1;
        end
      endcase

      if (press_done) begin
        press_flag <= 1'b1;
      end else if (flag_clr) begin
        press_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pb_debounce_events.sv
// Push-button conditioning stage: one independent debounce channel per
// button, all sharing only the clock and reset. Reset deassertion is
// expected to be synchronised upstream.
module pb_debounce_events
  import pb_debounce_events_pkg::*;
#(
  parameter int unsigned NUM_PB          = PB_NUM_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES_50M,
  parameter int unsigned CNT_W           = PB_CNT_W_50M
) (
  input  logic                 clkin_50,
  input  logic                 rst_n,
  pb_debounce_events_if.slave  pb_bus
);

  logic [NUM_PB-1:0] db_w;
  logic [NUM_PB-1:0] press_w;
  logic [NUM_PB-1:0] release_w;
  logic [NUM_PB-1:0] flag_w;

  for (genvar i = 0; i < NUM_PB; i++) begin : g_chan
    pb_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clkin_50      (clkin_50),
      .rst_n         (rst_n),
      .pb_n_raw      (pb_bus.pb_n[i]),
      .flag_clr      (pb_bus.flag_clr[i]),
      .pb_n_db       (db_w[i]),
      .press_pulse   (press_w[i]),
      .release_pulse (release_w[i]),
      .press_flag    (flag_w[i])
    );
  end

  assign pb_bus.pb_n_db       = db_w;
  assign pb_bus.press_pulse   = press_w;
  assign pb_bus.release_pulse = release_w;
  assign pb_bus.press_flag    = flag_w;

endmodule

// File: doc/pb_debounce_events.md
Name: pb_debounce_events

Overview:
- Push-button conditioning stage between the raw active-low board buttons and the button PIO.
- Per button: 2-FF synchronises the pin, applies a count-based debounce, and drives a clean active-low level to the PIO.
- Also emits one-cycle press/release pulses and keeps sticky press flags that software clears.
- Replaces ad-hoc filtering with deterministic, verifiable timing.

Parameters:
- NUM_PB, 4, number of buttons handled.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a new level (10 ms at 50 MHz); legal range 2 to 2^CNT_W-1.
- CNT_W, 19, debounce counter width.

Ports:
- clkin_50  input  1  system clock, 50 MHz, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- pb_n  input  NUM_PB  raw button pins, active-low, asynchronous to clkin_50.
- pb_n_db  output  NUM_PB  debounced level, active-low; feeds the button PIO.
- press_pulse  output  NUM_PB  one-cycle high on an accepted press (pb_n_db 1->0).
- release_pulse  output  NUM_PB  one-cycle high on an accepted release (pb_n_db 0->1).
- press_flag  output  NUM_PB  sticky high after an accepted press, until cleared.
- flag_clr  input  NUM_PB  per-bit synchronous clear of press_flag.

Behaviour:
- Reset: asynchronous assert; synchronous deassertion is handled at top level. While rst_n=0, all outputs and state are forced as follows:
  - sync FFs=1, pb_n_db=all 1s, press_pulse=0, release_pulse=0, press_flag=0.
  - counters=0, every channel FSM=UP.
- Synchroniser: two FFs per bit, reset to 1. s2 is the synchronised level.
- Per-channel FSM, four states:
  - UP: pb_n_db=1. If s2=0, go to CNT_DN with cnt=1.
  - CNT_DN: if s2=1, go to UP with cnt=0 (bounce abort, no pulse). Else if cnt==DEBOUNCE_CYCLES-1, go to DN and assert press_pulse for that transition cycle. Else cnt++.
  - DN: pb_n_db=0. If s2=1, go to CNT_UP with cnt=1.
  - CNT_UP: mirror of CNT_DN. Abort returns to DN; completion goes to UP with release_pulse.
- Output timing:
  - pb_n_db, press_pulse and release_pulse are registered.
  - For a clean pin edge held stable, pb_n_db changes exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new pin level.
  - press_pulse / release_pulse are high in the same cycle pb_n_db first shows the new level, for exactly 1 cycle.
- Counter: never wraps; it saturates by construction because the FSM leaves CNT_* at DEBOUNCE_CYCLES-1. Counter width is CNT_W and its value is 0 in UP and DN.
- press_flag:
  - Set in the cycle press_pulse is asserted.
  - Cleared by flag_clr bit.
  - Set and clear in the same cycle: set wins, flag stays 1.
  - flag_clr on an already-clear flag has no effect.
- Channel independence: channels share nothing except clock and reset; simultaneous presses on all buttons produce simultaneous pulses.
- Glitches: any input glitch shorter than DEBOUNCE_CYCLES (after synchronisation) produces no output change and no pulse.
- Reset mid-count: all progress is discarded. After release of reset, a button held low re-qualifies from cnt=0, giving a full DEBOUNCE_CYCLES+2 latency and one press_pulse.

Decomposition:
- Shared include/package holds:
  - FSM state encodings ST_UP=2'd0, ST_CNT_DN=2'd1, ST_DN=2'd2, ST_CNT_UP=2'd3.
  - Default DEBOUNCE_CYCLES / CNT_W constants for 50 MHz.
- One sub-module, pb_debounce_chan: synchroniser, counter, FSM, pulse and flag logic for a single button.
- Top instantiates NUM_PB copies with a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3 unless stated):
- Reset check: hold rst_n=0 with pb_n=4'b0000 -> pb_n_db=4'b1111, all pulses and flags 0. Release reset, keep pb_n=0 -> pb_n_db=4'b0000 exactly 6 edges later, press_pulse=4'b1111 for 1 cycle, press_flag=4'b1111.
- Clean press/release on pb_n[2]:
  - Press: 1->0 -> pb_n_db[2] falls 6 edges later with press_pulse[2] for 1 cycle.
  - Release: 0->1 -> pb_n_db[2] rises 6 edges later with release_pulse[2]. No other bit changes.
- Bounce rejection: pb_n[0] low 3 cycles, high 1, low 3, high -> pb_n_db[0] stays 1, no pulses, press_flag[0]=0.
- Flag handshake:
  - press_flag[1]=1; flag_clr[1]=1 for 1 cycle -> flag 0 next edge.
  - New press completes in the same cycle as flag_clr[1]=1 -> press_flag[1] stays 1.
- Reset mid-operation: pb_n[3] low 2 cycles into CNT_DN, pulse rst_n low -> pb_n_db[3]=1, cnt=0. Release with pb_n[3] still low -> exactly one press_pulse[3], 6 edges after reset release.
- Default parameters: DEBOUNCE_CYCLES=500000, pb_n[1] bounces for 2 ms then holds low -> single press_pulse[1] exactly 500002 cycles after the final falling edge.
